jk_cmd_sequencer: RTL and testbench

//   Upstream driver for the JK flip-flop stage. Accepts {op,len} commands over a

---
 rtl/jk_cmd_sequencer.sv | 144 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {op,len} commands in a small FIFO and drives the
// downstream JK flip-flop's J/K inputs with each op for len consecutive cycles.
// It also keeps a predicted copy of the flip-flop Q (q_model).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on rst and the registered
// FIFO level, so it never depends on cmd_valid. A pop in the same cycle does not
// raise cmd_ready when the FIFO is full.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_len,
  output logic                   J,
  output logic                   K,
  output logic                   done,
  output logic                   busy,
  output logic                   q_model,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t             r_state;
  logic [CNT_W+1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic [1:0]         r_op;
  logic [CNT_W-1:0]   r_rem;
  logic               r_q;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W+1:0]   w_head;
  logic [1:0]         w_head_op;
  logic [CNT_W-1:0]   w_head_len;
  logic [CNT_W-1:0]   w_head_rem;

  assign cmd_ready  = !rst && (r_level != C_DEPTH);
  assign w_push     = cmd_valid && cmd_ready;
  // The head is consumed when idle, or on the final cycle of the current run.
  assign w_pop      = (r_level != '0) && ((r_state == S_IDLE) || (r_rem == C_ONE));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_op  = w_head[CNT_W+1:CNT_W];
  assign w_head_len = w_head[CNT_W-1:0];
  // A zero length still drives the op for one cycle.
  assign w_head_rem = (w_head_len == '0) ? C_ONE : w_head_len;

  // FIFO storage: write the incoming command at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_len};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Drive FSM: loads the head command and counts down its run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op    <= w_head_op;
            r_rem   <= w_head_rem;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_rem == C_ONE) begin
            if (w_pop) begin
              r_op  <= w_head_op;
              r_rem <= w_head_rem;
            end else begin
              r_op    <= 2'b00;
              r_rem   <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_rem <= r_rem - 1'b1;
          end
        end
        default: begin
          r_op    <= 2'b00;
          r_rem   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Predicted flip-flop Q, updated from the J/K values currently being driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case (r_op)
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign J          = r_op[1];
  assign K          = r_op[0];
  assign done       = (r_state == S_DRIVE) && (r_rem == C_ONE);
  assign busy       = (r_state == S_DRIVE) || (r_level != '0);
  assign q_model    = r_q;
  assign fifo_level = r_level;
  assign dbg_state  = (r_state == S_DRIVE);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a drive-cycle scoreboard and a
// reference JK flip-flop for the co-simulation section.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             J;
  logic             K;
  logic             done;
  logic             busy;
  logic             q_model;
  logic [2:0]       fifo_level;
  logic             dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // {op[1:0], last_cycle_of_command} for every expected drive cycle
  logic [2:0] exp_q[$];
  logic       mon_en = 1'b0;

  // reference flip-flop
  logic ff_q;
  logic ff_arm  = 1'b0;
  logic ff_init = 1'b0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .J(J), .K(K), .done(done),
    .busy(busy), .q_model(q_model), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard: record accepted commands ----------------
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (cmd_valid && cmd_ready) begin
      int n;
      n = (cmd_len == 0) ? 1 : int'(cmd_len);
      for (int i = 0; i < n; i++) exp_q.push_back({cmd_op, (i == n - 1)});
    end
  end

  // ---------------- scoreboard: check every drive / idle cycle ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (dbg_state) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("sb_jk", {J, K}, e[2:1]);
          chk("sb_done", done, e[0]);
        end
      end else begin
        chk("sb_idle_jkd", {J, K, done}, 3'b000);
      end
    end
  end

  // ---------------- reference JK flip-flop ----------------
  always @(posedge clk) begin
    case ({J, K})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
    if (!ff_arm) ff_init <= 1'b0;
    else if ({J, K} == 2'b01 || {J, K} == 2'b10) ff_init <= 1'b1;
  end

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((busy || dbg_state) && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  // {J,K,done,q} per cycle for the back-to-back section
  logic [3:0] exp3 [10] = '{4'b0001, 4'b0101, 4'b0110, 4'b1100, 4'b1101,
                            4'b1100, 4'b1111, 4'b0010, 4'b0000, 4'b0000};
  logic       exp4_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [2:0] exp4_lvl [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
  logic       exp4_dn  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] ops4     [6] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01};

  initial begin
    int k;
    logic first_pending;
    logic acc;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0;

    // ---- 1: reset held 3 cycles ----
    tick(); mon_en = 1'b1;
    tick(); tick();
    chk("rst_jk", {J, K}, 2'b00);
    chk("rst_done", done, 0);
    chk("rst_q", q_model, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    // ---- 2: single set command, len 3 ----
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    chk("s2_level", fifo_level, 1);
    chk("s2_busy", busy, 1);
    chk("s2_jk_pre", {J, K}, 2'b00);
    tick();
    chk("s2_c1", {J, K, done, q_model}, 4'b1000);
    chk("s2_level0", fifo_level, 0);
    tick();
    chk("s2_c2", {J, K, done, q_model}, 4'b1001);
    tick();
    chk("s2_c3", {J, K, done, q_model}, 4'b1011);
    tick();
    chk("s2_after", {J, K, done, q_model}, 4'b0001);
    chk("s2_busy_end", busy, 0);

    // ---- 3: back-to-back {01,2},{11,4},{00,0} ----
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd2;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin cmd_op = 2'b11; cmd_len = 4'd4; end
      else if (i == 1) begin cmd_op = 2'b00; cmd_len = 4'd0; end
      else cmd_valid = 1'b0;
      chk($sformatf("b2b_%0d", i), {J, K, done, q_model}, exp3[i]);
      tick();
    end

    // ---- 4: overfill the FIFO with valid held ----
    k = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cmd_op = ops4[k]; cmd_len = 4'd4;
      chk($sformatf("full_rdy_%0d", c), cmd_ready, exp4_rdy[c]);
      chk($sformatf("full_lvl_%0d", c), fifo_level, exp4_lvl[c]);
      chk($sformatf("full_dn_%0d", c), done, exp4_dn[c]);
      acc = cmd_ready;
      tick();
      if (acc) k++;
    end
    cmd_valid = 1'b0;
    chk("full_accepted", k, 6);
    wait_idle("full_drain", 60);
    chk("full_sb_empty", exp_q.size(), 0);
    chk("full_q", q_model, 0);

    // ---- 5: reset in the middle of a toggle run ----
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd5;
    tick();
    cmd_op = 2'b10; cmd_len = 4'd2;
    tick();
    cmd_op = 2'b01; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    chk("mid_jkdq", {J, K, done, q_model}, 4'b1101);
    chk("mid_level", fifo_level, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_jkdq", {J, K, done, q_model}, 4'b0000);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mid_quiet_%0d", i), {J, K, done, busy, cmd_ready}, 5'b00001);
    end

    // ---- 6: random co-simulation against the reference flip-flop ----
    ff_arm = 1'b1;
    first_pending = 1'b1;
    for (int c = 0; c < 500; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = first_pending ? 2'b01 : 2'($urandom_range(0, 3));
      cmd_len   = CNT_W'($urandom_range(0, 5));
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) first_pending = 1'b0;
      if (ff_init) chk($sformatf("cosim_q_%0d", c), q_model, ff_q);
    end
    cmd_valid = 1'b0;
    wait_idle("cosim_drain", 200);
    chk("cosim_sb_empty", exp_q.size(), 0);
    chk("cosim_initialised", ff_init, 1);

    tick();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
